// File: rtl/mips_pkg.sv
// mips_pkg: MIPS instruction field positions, opcode constants and fetch FSM states
package mips_pkg;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_RESET = 6'h3F;
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} ifu_state_t;
endpackage

// File: rtl/ir_field_split.sv
// ir_field_split: combinational split of a 32-bit instruction word into MIPS fields
module ir_field_split
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);
  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign rs = ir[RS_MSB:RS_LSB];
  assign rt = ir[RT_MSB:RT_LSB];
  assign rd = ir[RD_MSB:RD_LSB];
  assign shamt = ir[SHAMT_MSB:SHAMT_LSB];
  assign funct = ir[FUNCT_MSB:FUNCT_LSB];
  assign imm16 = ir[IMM_MSB:IMM_LSB];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle fetch with IR latch, valid/ready handoff and PC redirect (IFU_PERF_CNT_EN adds fetch/stall counters)
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              busy
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  ifu_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] pc_n, addr_n, redir_pc;
  logic [DATA_W-1:0] ir_n;
  logic rd_n, valid_n, discard, discard_n, hs;
  assign redir_pc = redirect_pc & ~ADDR_W'(3);
  assign hs = instr_valid && instr_ready;
  assign pc_plus4 = pc + ADDR_W'(4);
  assign busy = (state == S_WAIT);
  // state register
  always_ff @(posedge clk)
    state <= reset ? S_ISSUE : state_n;
  // datapath registers; reset abandons any in-flight read
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= ADDR_W'(RESET_PC);
      ir <= '0;
      mem_addr <= '0;
      mem_rd <= 1'b0;
      instr_valid <= 1'b0;
      cnt <= '0;
      discard <= 1'b0;
    end else begin
      pc <= pc_n;
      ir <= ir_n;
      mem_addr <= addr_n;
      mem_rd <= rd_n;
      instr_valid <= valid_n;
      cnt <= cnt_n;
      discard <= discard_n;
    end
  end
  // next state: a redirect always wins the PC; a redirected read still runs to completion but is dropped
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    addr_n = mem_addr;
    rd_n = 1'b0;
    valid_n = instr_valid;
    cnt_n = cnt;
    discard_n = discard;
    case (state)
      S_ISSUE: begin
        if (redirect_valid) pc_n = redir_pc;
        else begin
          addr_n = pc;
          rd_n = 1'b1;
          cnt_n = CNT_W'(MEM_LAT);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          discard_n = 1'b1;
          pc_n = redir_pc;
        end
        if (cnt == '0) begin
          if (discard || redirect_valid) begin
            discard_n = 1'b0;
            state_n = S_ISSUE;
          end else begin
            ir_n = mem_rdata;
            valid_n = 1'b1;
            state_n = S_HOLD;
          end
        end else cnt_n = cnt - CNT_W'(1);
      end
      S_HOLD: begin
        if (redirect_valid || hs) begin
          valid_n = 1'b0;
          pc_n = redirect_valid ? redir_pc : pc_plus4;
          state_n = S_ISSUE;
        end
      end
      default: state_n = S_ISSUE;
    endcase
  end
  ir_field_split u_split (
    .ir(ir[31:0]),
    .opcode(opcode),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .shamt(shamt),
    .funct(funct),
    .imm16(imm16)
  );
`ifdef IFU_PERF_CNT_EN
  // handshakes completed and cycles the consumer held off a valid instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(hs);
      stall_cnt <= stall_cnt + 32'(instr_valid && !instr_ready);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch scenarios with a scoreboard checking every delivered instruction
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, ir, pc, pc_plus4;
  logic mem_rd, redirect_valid, instr_valid, instr_ready, busy;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif
  typedef struct packed {logic [31:0] pc; logic [31:0] ir;} exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  bit prev_rd = 1'b0;
  logic p1v = 1'b0, p2v = 1'b0;
  logic [31:0] p1a = '0, p2a = '0;
  always #5 clk = ~clk;
  instr_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .ir(ir),
    .opcode(opcode),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .shamt(shamt),
    .funct(funct),
    .imm16(imm16),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .busy(busy)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt)
`endif
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (32'h0043_0820 ^ a);
  endfunction
  // memory with a fixed two-cycle read latency; garbage whenever no read is returning
  always @(posedge clk) begin
    p1v <= mem_rd;
    p1a <= mem_addr;
    p2v <= p1v;
    p2a <= p1a;
  end
  assign mem_rdata = p2v ? mem_word(p2a) : 32'hDEAD_BEEF;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rd(input string name, input logic [31:0] addr);
    bit saw_valid = 1'b0;
    for (int i = 0; i < 20 && mem_rd !== 1'b1; i++) begin
      saw_valid |= (instr_valid === 1'b1);
      tick();
    end
    chk({name, "_novalid"}, 32'(saw_valid), 32'h0);
    chk({name, "_rd"}, 32'(mem_rd), 32'h1);
    chk({name, "_addr"}, mem_addr, addr);
  endtask
  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
    chk({name, "_valid"}, 32'(instr_valid), 32'h1);
  endtask
  // monitor: read strobe spacing and every delivered instruction against the scoreboard
  always @(negedge clk) begin
    if (mem_rd) chk("rd_gap", 32'(prev_rd), 32'h0);
    prev_rd <= mem_rd;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got instr %h at pc %h expected none", ir, pc);
      end else begin
        e = sb.pop_front();
        chk("sb_ir", ir, e.ir);
        chk("sb_pc", pc, e.pc);
        chk("sb_pc4", pc_plus4, e.pc + 32'd4);
        chk("sb_opcode", 32'(opcode), 32'(e.ir[31:26]));
        chk("sb_funct", 32'(funct), 32'(e.ir[5:0]));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rd", 32'(mem_rd), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    // test 1: first fetch timing and field split
    sb.push_back('{pc: 32'h0, ir: 32'h2008_0005});
    reset = 1'b0;
    chk("t1_c0_rd", 32'(mem_rd), 32'h0);
    tick();
    chk("t1_c1_rd", 32'(mem_rd), 32'h1);
    chk("t1_c1_addr", mem_addr, 32'h0);
    chk("t1_c1_busy", 32'(busy), 32'h1);
    tick();
    tick();
    chk("t1_c3_valid", 32'(instr_valid), 32'h0);
    tick();
    chk("t1_c4_valid", 32'(instr_valid), 32'h1);
    chk("t1_opcode", 32'(opcode), 32'h08);
    chk("t1_rs", 32'(rs), 32'h0);
    chk("t1_rt", 32'(rt), 32'h8);
    chk("t1_imm16", 32'(imm16), 32'h5);
    // test 2: consumer stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      chk("t2_ir_stable", ir, 32'h2008_0005);
      chk("t2_no_rd", 32'(mem_rd), 32'h0);
      tick();
    end
    chk("t2_still_valid", 32'(instr_valid), 32'h1);
`ifdef IFU_PERF_CNT_EN
    chk("t2_stall_cnt", stall_cnt, 32'd5);
`endif
    instr_ready = 1'b1;
    tick();
    chk("t2_dropped", 32'(instr_valid), 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("t2_stall_cnt_hold", stall_cnt, 32'd5);
    chk("t2_fetch_cnt", fetch_cnt, 32'd1);
`endif
    wait_rd("t2", 32'h4);
    // test 3: redirect while the read to 4 is in flight
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk("t3_pc", pc, 32'h100);
    sb.push_back('{pc: 32'h100, ir: 32'h0043_0920});
    wait_rd("t3", 32'h100);
    wait_valid("t3");
    tick();
    // test 4: redirect in S_ISSUE to 0x40, then redirect coincident with handshake
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t4_issue_no_rd", 32'(mem_rd), 32'h0);
    chk("t4_issue_pc", pc, 32'h40);
    wait_rd("t4a", 32'h40);
    sb.push_back('{pc: 32'h40, ir: 32'h0043_0860});
    instr_ready = 1'b0;
    wait_valid("t4a");
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("t4_pc", pc, 32'h200);
    chk("t4_valid", 32'(instr_valid), 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("t4_fetch_cnt", fetch_cnt, 32'd3);
`endif
    sb.push_back('{pc: 32'h200, ir: 32'h0043_0A20});
    wait_rd("t4b", 32'h200);
    wait_valid("t4b");
    tick();
    // test 5: PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFD;
    tick();
    redirect_valid = 1'b0;
    chk("t5_no_rd", 32'(mem_rd), 32'h0);
    chk("t5_pc", pc, 32'hFFFF_FFFC);
    chk("t5_pc4_wrap", pc_plus4, 32'h0);
    sb.push_back('{pc: 32'hFFFF_FFFC, ir: 32'hFFBC_F7DC});
    wait_rd("t5", 32'hFFFF_FFFC);
    instr_ready = 1'b0;
    wait_valid("t5");
    instr_ready = 1'b1;
    tick();
    chk("t5_pc_after", pc, 32'h0);
    chk("t5_pc4_after", pc_plus4, 32'h4);
    // test 6: reset pulse while the read to 4 is in flight
    sb.push_back('{pc: 32'h0, ir: 32'h2008_0005});
    wait_rd("t6a", 32'h0);
    wait_valid("t6a");
    tick();
    wait_rd("t6b", 32'h4);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_pc", pc, 32'h0);
    chk("t6_ir", ir, 32'h0);
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_rd", 32'(mem_rd), 32'h0);
    chk("t6_valid", 32'(instr_valid), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("t6_fetch_cnt", fetch_cnt, 32'd0);
    chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif
    chk("t6_sb_drained", 32'(sb.size()), 32'h0);
    reset = 1'b0;
    sb.push_back('{pc: 32'h0, ir: 32'h2008_0005});
    wait_rd("t6c", 32'h0);
    wait_valid("t6c");
    tick();
    tick();
    chk("final_sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
